// File: rtl/alu_pkg.sv
// Shared constants for the ALU control path: op classes, R-type func codes, ALU selects.
// The ALU_CTRL_EXT_EN extension codes are always defined here; only the decoder gates them.
package alu_pkg;

  localparam int CTRL_W = 4;
  localparam int FUNC_W = 6;
  localparam int OP_W   = 2;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [FUNC_W-1:0] func_t;
  typedef logic [CTRL_W-1:0] sel_t;

  // Operation class from main control
  localparam op_t OPC_MEM   = 2'b00;
  localparam op_t OPC_BR    = 2'b01;
  localparam op_t OPC_RTYPE = 2'b10;
  localparam op_t OPC_RSVD  = 2'b11;

  // Base R-type function codes
  localparam func_t F_ADD  = 6'b100000;
  localparam func_t F_ADDU = 6'b100001;
  localparam func_t F_SUB  = 6'b100010;
  localparam func_t F_SUBU = 6'b100011;
  localparam func_t F_AND  = 6'b100100;
  localparam func_t F_OR   = 6'b100101;
  localparam func_t F_SLT  = 6'b101010;

  // Extension R-type function codes
  localparam func_t F_NOR  = 6'b100111;
  localparam func_t F_XOR  = 6'b100110;
  localparam func_t F_SLL  = 6'b000000;
  localparam func_t F_SRL  = 6'b000010;
  localparam func_t F_SLTU = 6'b101011;

  // ALU operation selects
  localparam sel_t ALU_AND  = 4'b0000;
  localparam sel_t ALU_OR   = 4'b0001;
  localparam sel_t ALU_ADD  = 4'b0010;
  localparam sel_t ALU_SUB  = 4'b0110;
  localparam sel_t ALU_SLT  = 4'b0111;
  localparam sel_t ALU_SLL  = 4'b1000;
  localparam sel_t ALU_SRL  = 4'b1001;
  localparam sel_t ALU_SLTU = 4'b1010;
  localparam sel_t ALU_NOR  = 4'b1100;
  localparam sel_t ALU_XOR  = 4'b1101;
  localparam sel_t ALU_BAD  = 4'b1111;

  typedef struct packed {
    sel_t sel;
    logic illegal;
  } dec_t;

  function automatic dec_t mk_dec(input sel_t sel, input logic illegal);
    dec_t d;
    d.sel     = sel;
    d.illegal = illegal;
    return d;
  endfunction

  localparam dec_t DEC_BAD = '{sel: ALU_BAD, illegal: 1'b1};

endpackage

// File: rtl/alu_func_decode.sv
// Combinational R-type func -> {ALU select, illegal} table; ALU_CTRL_EXT_EN adds nor/xor/sll/srl/sltu.
// Latency: none (pure combinational). Backpressure: none.
module alu_func_decode
  import alu_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  output dec_t              dec
);

  always_comb begin
    dec = DEC_BAD;
    // Unknown func bits match no item and land on the default
    case (func)
      F_ADD:   dec = mk_dec(ALU_ADD, 1'b0);
      F_ADDU:  dec = mk_dec(ALU_ADD, 1'b0);
      F_SUB:   dec = mk_dec(ALU_SUB, 1'b0);
      F_SUBU:  dec = mk_dec(ALU_SUB, 1'b0);
      F_AND:   dec = mk_dec(ALU_AND, 1'b0);
      F_OR:    dec = mk_dec(ALU_OR,  1'b0);
      F_SLT:   dec = mk_dec(ALU_SLT, 1'b0);
`ifdef ALU_CTRL_EXT_EN
      F_NOR:   dec = mk_dec(ALU_NOR,  1'b0);
      F_XOR:   dec = mk_dec(ALU_XOR,  1'b0);
      F_SLL:   dec = mk_dec(ALU_SLL,  1'b0);
      F_SRL:   dec = mk_dec(ALU_SRL,  1'b0);
      F_SLTU:  dec = mk_dec(ALU_SLTU, 1'b0);
`endif
      default: dec = DEC_BAD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_unit.sv
// ALU control: muxes op class with the R-type func decode and registers {alu_control, illegal}.
// Latency: 1 cycle, samples every cycle, no backpressure. Optional ALU_CTRL_EXT_EN widens the func table.
module alu_ctrl_unit
  import alu_pkg::*;
#(
  parameter int CTRL_W = alu_pkg::CTRL_W,
  parameter int FUNC_W = alu_pkg::FUNC_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FUNC_W-1:0] func,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal
);

  dec_t func_dec;
  dec_t nxt_dec;

  alu_func_decode u_func_decode (
    .func (func),
    .dec  (func_dec)
  );

  // func only steers the result for R-type, so it is a true don't-care elsewhere
  always_comb begin
    nxt_dec = DEC_BAD;
    case (alu_op)
      OPC_MEM:   nxt_dec = mk_dec(ALU_ADD, 1'b0);
      OPC_BR:    nxt_dec = mk_dec(ALU_SUB, 1'b0);
      OPC_RTYPE: nxt_dec = func_dec;
      default:   nxt_dec = DEC_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_control <= ALU_ADD;
      illegal     <= 1'b0;
    end else begin
      alu_control <= nxt_dec.sel;
      illegal     <= nxt_dec.illegal;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Bench for alu_ctrl_unit: directed vector table, then random traffic against a lookup-table model.
module tb_alu_ctrl_unit;

  logic       clk;
  logic       rst;
  logic [1:0] alu_op;
  logic [5:0] func;
  logic [3:0] alu_control;
  logic       illegal;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] prev_ctrl;
  logic       prev_ill;
  bit         prev_vld = 0;

  // Reference: legal R-type func codes and the select each produces
  logic [3:0] rtype_map [logic [5:0]];

  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic [5:0] func;
    bit         func_x;
    logic [3:0] ctrl;
    logic       ill;
    string      name;
  } vec_t;

  vec_t vecs[$];

  alu_ctrl_unit dut (
    .clk         (clk),
    .rst         (rst),
    .alu_op      (alu_op),
    .func        (func),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [1:0] op, input logic [5:0] f,
                              input bit fx, input logic [3:0] c, input logic i, input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.func = f; v.func_x = fx; v.ctrl = c; v.ill = i; v.name = nm;
    return v;
  endfunction

  task automatic model(input logic r, input logic [1:0] op, input logic [5:0] f,
                       output logic [3:0] c, output logic i);
    if (r) begin
      c = 4'd2; i = 1'b0;
    end else if (op == 2'd0) begin
      c = 4'd2; i = 1'b0;
    end else if (op == 2'd1) begin
      c = 4'd6; i = 1'b0;
    end else if (op == 2'd2 && !$isunknown(f) && rtype_map.exists(f)) begin
      c = rtype_map[f]; i = 1'b0;
    end else begin
      c = 4'hF; i = 1'b1;
    end
  endtask

  task automatic check(input string nm, input logic [3:0] ec, input logic ei);
    n_total++;
    if (!$isunknown({alu_control, illegal}) && alu_control === ec && illegal === ei)
      n_pass++;
    else
      $display("FAIL %s: got ctrl=%b ill=%b, expected ctrl=%b ill=%b",
               nm, alu_control, illegal, ec, ei);
  endtask

  // Drive at negedge, confirm outputs hold until the edge, then check after it
  task automatic step(input logic r, input logic [1:0] op, input logic [5:0] f, input bit fx,
                      input logic [3:0] ec, input logic ei, input string nm);
    @(negedge clk);
    rst    = r;
    alu_op = op;
    func   = fx ? 6'bxxxxxx : f;
    #1;
    if (prev_vld) check({nm, "_hold"}, prev_ctrl, prev_ill);
    @(posedge clk);
    #1;
    check(nm, ec, ei);
    prev_ctrl = ec;
    prev_ill  = ei;
    prev_vld  = 1;
  endtask

  initial begin
    logic [3:0] ec;
    logic       ei;
    logic [5:0] f;
    logic [1:0] op;
    logic       r;

    rtype_map[6'b100000] = 4'b0010;
    rtype_map[6'b100001] = 4'b0010;
    rtype_map[6'b100010] = 4'b0110;
    rtype_map[6'b100011] = 4'b0110;
    rtype_map[6'b100100] = 4'b0000;
    rtype_map[6'b100101] = 4'b0001;
    rtype_map[6'b101010] = 4'b0111;
`ifdef ALU_CTRL_EXT_EN
    rtype_map[6'b100111] = 4'b1100;
    rtype_map[6'b100110] = 4'b1101;
    rtype_map[6'b000000] = 4'b1000;
    rtype_map[6'b000010] = 4'b1001;
    rtype_map[6'b101011] = 4'b1010;
`endif

    rst = 1'b1; alu_op = 2'b00; func = 6'b0;

    vecs.push_back(mk(1, 2'b00, 6'b000000, 0, 4'b0010, 0, "reset"));
    vecs.push_back(mk(0, 2'b00, 6'b000000, 1, 4'b0010, 0, "mem_func_x"));
    vecs.push_back(mk(0, 2'b01, 6'b000000, 1, 4'b0110, 0, "br_func_x"));
    vecs.push_back(mk(0, 2'b10, 6'b000000, 1, 4'b1111, 1, "rtype_func_x"));
    vecs.push_back(mk(0, 2'b10, 6'b100000, 0, 4'b0010, 0, "r_add"));
    vecs.push_back(mk(0, 2'b10, 6'b100010, 0, 4'b0110, 0, "r_sub"));
    vecs.push_back(mk(0, 2'b10, 6'b100100, 0, 4'b0000, 0, "r_and"));
    vecs.push_back(mk(0, 2'b10, 6'b100101, 0, 4'b0001, 0, "r_or"));
    vecs.push_back(mk(0, 2'b10, 6'b101010, 0, 4'b0111, 0, "r_slt"));
    vecs.push_back(mk(0, 2'b10, 6'b100001, 0, 4'b0010, 0, "r_addu"));
    vecs.push_back(mk(0, 2'b10, 6'b100011, 0, 4'b0110, 0, "r_subu"));
    vecs.push_back(mk(0, 2'b11, 6'b100000, 0, 4'b1111, 1, "op_rsvd"));
    vecs.push_back(mk(0, 2'b10, 6'b001000, 0, 4'b1111, 1, "r_jr_bad"));
    vecs.push_back(mk(0, 2'b10, 6'b111111, 0, 4'b1111, 1, "r_all_ones"));
    vecs.push_back(mk(1, 2'b01, 6'b000000, 0, 4'b0010, 0, "rst_over_br"));
    vecs.push_back(mk(0, 2'b01, 6'b000000, 0, 4'b0110, 0, "br_after_rst"));
    vecs.push_back(mk(0, 2'b11, 6'b000000, 0, 4'b1111, 1, "rsvd_again"));
    vecs.push_back(mk(1, 2'b11, 6'b000000, 0, 4'b0010, 0, "rst_over_rsvd"));
    vecs.push_back(mk(0, 2'b00, 6'b111111, 0, 4'b0010, 0, "mem_after_rst"));
`ifdef ALU_CTRL_EXT_EN
    vecs.push_back(mk(0, 2'b10, 6'b100111, 0, 4'b1100, 0, "r_nor"));
    vecs.push_back(mk(0, 2'b10, 6'b100110, 0, 4'b1101, 0, "r_xor"));
    vecs.push_back(mk(0, 2'b10, 6'b000000, 0, 4'b1000, 0, "r_sll"));
    vecs.push_back(mk(0, 2'b10, 6'b000010, 0, 4'b1001, 0, "r_srl"));
    vecs.push_back(mk(0, 2'b10, 6'b101011, 0, 4'b1010, 0, "r_sltu"));
`else
    vecs.push_back(mk(0, 2'b10, 6'b100111, 0, 4'b1111, 1, "r_nor_off"));
    vecs.push_back(mk(0, 2'b10, 6'b000010, 0, 4'b1111, 1, "r_srl_off"));
`endif

    foreach (vecs[k]) begin
      ec = vecs[k].ctrl;
      ei = vecs[k].ill;
      // A two-state simulator turns the driven X into a real code; predict from what it became
      if (vecs[k].func_x && vecs[k].op == 2'b10) begin
        @(negedge clk);
        func = 6'bxxxxxx;
        if (!$isunknown(func)) model(1'b0, 2'b10, func, ec, ei);
      end
      step(vecs[k].rst, vecs[k].op, vecs[k].func, vecs[k].func_x, ec, ei, vecs[k].name);
    end

    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(0, 19) == 0);
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 11))
          0: f = 6'b100000;  1: f = 6'b100001;  2: f = 6'b100010;  3: f = 6'b100011;
          4: f = 6'b100100;  5: f = 6'b100101;  6: f = 6'b101010;  7: f = 6'b100111;
          8: f = 6'b100110;  9: f = 6'b000000; 10: f = 6'b000010; default: f = 6'b101011;
        endcase
      end else begin
        f = 6'($urandom_range(0, 63));
      end
      model(r, op, f, ec, ei);
      step(r, op, f, 0, ec, ei, $sformatf("rand%0d_op%b_f%b", n, op, f));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
